decode_hazard_unit: RTL and testbench

// - Decode-stage hazard/forwarding controller feeding the decode forwarding mux: drives D_rs1_sel/D_rs2_sel and f_rs1_data_out/f_rs2_data_out.
// - Keeps a 3-slot shadow scoreboard (E, M, W) of in-flight destination writes and detects RAW hazards against them.
// - Raises a load-use stall and applies branch-flush bubbles for the fetch and decode stages.

---
 rtl/decode_hazard_unit.sv | 144 ++++++++++++++
 tb/tb_decode_hazard_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_hazard_unit.sv
// Decode-stage hazard and forwarding controller with a 3-slot (E/M/W) destination scoreboard.
// Optional HAZARD_PERF_EN adds saturating stall/flush/forward event counters.
module decode_hazard_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned PERF_CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              D_valid,
  input  logic [REG_AW-1:0] D_rs1_addr,
  input  logic [REG_AW-1:0] D_rs2_addr,
  input  logic              D_rs1_use,
  input  logic              D_rs2_use,
  input  logic [REG_AW-1:0] D_rd_addr,
  input  logic              D_reg_we,
  input  logic              D_is_load,
  input  logic [XLEN-1:0]   E_result,
  input  logic [XLEN-1:0]   M_result,
  input  logic [XLEN-1:0]   W_result,
  input  logic              E_branch_taken,
  input  logic              mem_stall,
  output logic              D_rs1_sel,
  output logic              D_rs2_sel,
  output logic [XLEN-1:0]   f_rs1_data_out,
  output logic [XLEN-1:0]   f_rs2_data_out,
  output logic              F_stall,
  output logic              D_stall,
  output logic              D_flush
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_stall_cnt,
  output logic [PERF_CNT_W-1:0] perf_flush_cnt,
  output logic [PERF_CNT_W-1:0] perf_fwd_cnt
`endif
);

  typedef struct packed {
    logic              we;
    logic              is_load;
    logic [REG_AW-1:0] rd;
  } slot_t;

  slot_t e_q, m_q, w_q;
  slot_t d_entry;
  logic  e_hit1, m_hit1, w_hit1;
  logic  e_hit2, m_hit2, w_hit2;
  logic  load_use;
  logic  bubble;

  function automatic logic hit(input slot_t s, input logic [REG_AW-1:0] rs, input logic use_rs);
    return s.we && (s.rd == rs) && (rs != '0) && use_rs;
  endfunction

  // Hazard detection and scoreboard entry for the instruction now in decode
  always_comb begin
    e_hit1   = hit(e_q, D_rs1_addr, D_rs1_use);
    m_hit1   = hit(m_q, D_rs1_addr, D_rs1_use);
    w_hit1   = hit(w_q, D_rs1_addr, D_rs1_use);
    e_hit2   = hit(e_q, D_rs2_addr, D_rs2_use);
    m_hit2   = hit(m_q, D_rs2_addr, D_rs2_use);
    w_hit2   = hit(w_q, D_rs2_addr, D_rs2_use);
    load_use = D_valid && e_q.is_load && (e_hit1 || e_hit2);
    bubble   = load_use || E_branch_taken;
    d_entry.we      = D_valid && D_reg_we && !bubble;
    d_entry.is_load = D_is_load;
    d_entry.rd      = D_rd_addr;
  end

  // Forward mux controls: youngest producer wins, a load still in E cannot forward
  always_comb begin
    D_rs1_sel      = 1'b0;
    D_rs2_sel      = 1'b0;
    f_rs1_data_out = '0;
    f_rs2_data_out = '0;
    if (!rst) begin
      if (e_hit1 && !e_q.is_load) begin
        D_rs1_sel = 1'b1; f_rs1_data_out = E_result;
      end else if (m_hit1) begin
        D_rs1_sel = 1'b1; f_rs1_data_out = M_result;
      end else if (w_hit1) begin
        D_rs1_sel = 1'b1; f_rs1_data_out = W_result;
      end
      if (e_hit2 && !e_q.is_load) begin
        D_rs2_sel = 1'b1; f_rs2_data_out = E_result;
      end else if (m_hit2) begin
        D_rs2_sel = 1'b1; f_rs2_data_out = M_result;
      end else if (w_hit2) begin
        D_rs2_sel = 1'b1; f_rs2_data_out = W_result;
      end
    end
  end

  // Pipeline control: back-pressure dominates, then flush, then load-use stall
  always_comb begin
    F_stall = 1'b0;
    D_stall = 1'b0;
    D_flush = 1'b0;
    if (!rst) begin
      if (mem_stall) begin
        F_stall = 1'b1;
        D_stall = 1'b1;
      end else if (E_branch_taken) begin
        D_flush = 1'b1;
      end else if (load_use) begin
        F_stall = 1'b1;
        D_stall = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else if (!mem_stall) begin
      w_q <= m_q;
      m_q <= e_q;
      e_q <= d_entry;
    end
  end

`ifdef HAZARD_PERF_EN
  logic fwd_any;
  assign fwd_any = D_rs1_sel || D_rs2_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_fwd_cnt   <= '0;
    end else begin
      if (load_use && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + PERF_CNT_W'(1);
      if (E_branch_taken && (perf_flush_cnt != '1))
        perf_flush_cnt <= perf_flush_cnt + PERF_CNT_W'(1);
      if (fwd_any && (perf_fwd_cnt != '1))
        perf_fwd_cnt <= perf_fwd_cnt + PERF_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_decode_hazard_unit.sv
// Scoreboard bench for decode_hazard_unit: directed scenarios followed by random traffic,
// each cycle's expectation comes from an in-bench list model of in-flight register writes.
module tb_decode_hazard_unit;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned PCW    = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              D_valid, D_rs1_use, D_rs2_use, D_reg_we, D_is_load;
  logic [REG_AW-1:0] D_rs1_addr, D_rs2_addr, D_rd_addr;
  logic [XLEN-1:0]   E_result, M_result, W_result;
  logic              E_branch_taken, mem_stall;
  logic              D_rs1_sel, D_rs2_sel, F_stall, D_stall, D_flush;
  logic [XLEN-1:0]   f_rs1_data_out, f_rs2_data_out;
`ifdef HAZARD_PERF_EN
  logic [PCW-1:0]    perf_stall_cnt, perf_flush_cnt, perf_fwd_cnt;
`endif

  decode_hazard_unit #(.XLEN(XLEN), .REG_AW(REG_AW), .PERF_CNT_W(PCW)) dut (
    .clk(clk), .rst(rst),
    .D_valid(D_valid), .D_rs1_addr(D_rs1_addr), .D_rs2_addr(D_rs2_addr),
    .D_rs1_use(D_rs1_use), .D_rs2_use(D_rs2_use), .D_rd_addr(D_rd_addr),
    .D_reg_we(D_reg_we), .D_is_load(D_is_load),
    .E_result(E_result), .M_result(M_result), .W_result(W_result),
    .E_branch_taken(E_branch_taken), .mem_stall(mem_stall),
    .D_rs1_sel(D_rs1_sel), .D_rs2_sel(D_rs2_sel),
    .f_rs1_data_out(f_rs1_data_out), .f_rs2_data_out(f_rs2_data_out),
    .F_stall(F_stall), .D_stall(D_stall), .D_flush(D_flush)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
    .perf_fwd_cnt(perf_fwd_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst, valid, u1, u2, we, ld, br, ms;
    int rs1, rs2, rd;
    bit [31:0] er, mr, wr;
  } stim_t;

  typedef struct {
    bit sel1, sel2, fs, ds, fl, dc1, dc2;
    bit [31:0] d1, d2;
    bit [31:0] pstall, pflush, pfwd;
  } exp_t;

  typedef struct { bit we, ld; int rd; } wr_t;

  stim_t nxt, cur;
  exp_t  sbq[$];
  wr_t   inflight[3];  // index 0 = youngest (EX), 2 = oldest (WB)
  int    n_vec = 0, n_err = 0;
  bit    stim_done = 0;
  longint cnt_stall = 0, cnt_flush = 0, cnt_fwd = 0;

  function automatic bit reads(int k, int rs, bit u);
    return inflight[k].we && inflight[k].rd == rs && rs != 0 && u;
  endfunction

  function automatic bit is_load_use(stim_t s);
    return s.valid && inflight[0].ld && (reads(0, s.rs1, s.u1) || reads(0, s.rs2, s.u2));
  endfunction

  // Nearest producer that can supply a value; a load still in EX cannot
  function automatic void fwd(stim_t s, int rs, bit u, output bit sel, output bit [31:0] d);
    bit [31:0] vals[3];
    vals[0] = s.er; vals[1] = s.mr; vals[2] = s.wr;
    sel = 0; d = 0;
    for (int k = 0; k < 3; k++) begin
      if (reads(k, rs, u) && !(k == 0 && inflight[0].ld)) begin
        sel = 1; d = vals[k];
        return;
      end
    end
  endfunction

  function automatic void clear_model();
    for (int k = 0; k < 3; k++) inflight[k] = '{we: 0, ld: 0, rd: 0};
  endfunction

  function automatic exp_t expect_now(stim_t s);
    exp_t e;
    bit lu;
    e = '{default: 0};
    e.pstall = 32'(cnt_stall); e.pflush = 32'(cnt_flush); e.pfwd = 32'(cnt_fwd);
    if (s.rst) return e;
    lu = is_load_use(s);
    fwd(s, s.rs1, s.u1, e.sel1, e.d1);
    fwd(s, s.rs2, s.u2, e.sel2, e.d2);
    e.dc1 = lu && reads(0, s.rs1, s.u1);
    e.dc2 = lu && reads(0, s.rs2, s.u2);
    if (s.ms)      begin e.fs = 1; e.ds = 1; end
    else if (s.br) e.fl = 1;
    else if (lu)   begin e.fs = 1; e.ds = 1; end
    return e;
  endfunction

  // Clock edge of the model: advance in-flight writes and event counts
  function automatic void model_edge(stim_t s);
    bit lu, s1, s2;
    bit [31:0] d;
    if (s.rst) begin
      clear_model();
      cnt_stall = 0; cnt_flush = 0; cnt_fwd = 0;
      return;
    end
    lu = is_load_use(s);
    fwd(s, s.rs1, s.u1, s1, d);
    fwd(s, s.rs2, s.u2, s2, d);
    if (lu) cnt_stall++;
    if (s.br) cnt_flush++;
    if (s1 || s2) cnt_fwd++;
    if (!s.ms) begin
      inflight[2] = inflight[1];
      inflight[1] = inflight[0];
      inflight[0] = '{we: s.valid && s.we && !(lu || s.br), ld: s.ld, rd: s.rd};
    end
  endfunction

  function automatic void idle();
    nxt = '{default: 0};
    nxt.er = 32'hE0E0_0000; nxt.mr = 32'hA0A0_0000; nxt.wr = 32'hB0B0_0000;
  endfunction

  task automatic apply();
    rst = cur.rst; D_valid = cur.valid;
    D_rs1_addr = REG_AW'(cur.rs1); D_rs2_addr = REG_AW'(cur.rs2);
    D_rs1_use = cur.u1; D_rs2_use = cur.u2;
    D_rd_addr = REG_AW'(cur.rd); D_reg_we = cur.we; D_is_load = cur.ld;
    E_result = cur.er; M_result = cur.mr; W_result = cur.wr;
    E_branch_taken = cur.br; mem_stall = cur.ms;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge(cur);
    #1;
    cur = nxt;
    apply();
    if (cur.rst) clear_model();
    sbq.push_back(expect_now(cur));
  endtask

  task automatic chk(string name, bit [31:0] act, bit [31:0] req);
    if (act !== req) begin
      n_err++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, act, req);
    end
  endtask

  // Monitor: the controller answers every cycle, so one queued expectation per cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        n_vec++;
        if (!e.dc1) begin
          chk("rs1_sel", 32'(D_rs1_sel), 32'(e.sel1));
          chk("rs1_data", f_rs1_data_out, e.d1);
        end
        if (!e.dc2) begin
          chk("rs2_sel", 32'(D_rs2_sel), 32'(e.sel2));
          chk("rs2_data", f_rs2_data_out, e.d2);
        end
        chk("F_stall", 32'(F_stall), 32'(e.fs));
        chk("D_stall", 32'(D_stall), 32'(e.ds));
        chk("D_flush", 32'(D_flush), 32'(e.fl));
`ifdef HAZARD_PERF_EN
        chk("perf_stall", perf_stall_cnt, e.pstall);
        chk("perf_flush", perf_flush_cnt, e.pflush);
        chk("perf_fwd", perf_fwd_cnt, e.pfwd);
`endif
      end
    end
  end

  initial begin
    idle(); nxt.rst = 1; nxt.ms = 1; nxt.br = 1;
    cur = nxt; apply(); clear_model();
    repeat (2) cycle();                              // reset dominates stall/flush inputs
    idle(); cycle();

    // add x5 then add x6,x5: forward from E
    idle(); nxt.valid = 1; nxt.rd = 5; nxt.we = 1; cycle();
    idle(); nxt.valid = 1; nxt.rs1 = 5; nxt.u1 = 1; nxt.rd = 6; nxt.we = 1; nxt.er = 32'h0000_1234; cycle();
    idle(); cycle(); cycle();

    // lw x7 then use x7 as rs2: one stall, then forward from M
    idle(); nxt.valid = 1; nxt.rd = 7; nxt.we = 1; nxt.ld = 1; cycle();
    idle(); nxt.valid = 1; nxt.rs2 = 7; nxt.u2 = 1; nxt.rd = 8; nxt.we = 1; cycle();
    nxt.mr = 32'hDEAD_BEEF; cycle();
    idle(); cycle(); cycle();

    // x3 in M and E: E wins; destination x0 never forwards
    idle(); nxt.valid = 1; nxt.rd = 3; nxt.we = 1; cycle();
    cycle();
    idle(); nxt.valid = 1; nxt.rs1 = 3; nxt.u1 = 1; nxt.rs2 = 3; nxt.u2 = 1;
    nxt.er = 32'h11; nxt.mr = 32'h22; cycle();
    idle(); nxt.valid = 1; nxt.rd = 0; nxt.we = 1; cycle();
    idle(); nxt.valid = 1; nxt.rs1 = 0; nxt.u1 = 1; nxt.rs2 = 0; nxt.u2 = 1; cycle();
    idle(); cycle(); cycle(); cycle();

    // branch together with load-use: flush wins, no write enters E
    idle(); nxt.valid = 1; nxt.rd = 9; nxt.we = 1; nxt.ld = 1; cycle();
    idle(); nxt.valid = 1; nxt.rs1 = 9; nxt.u1 = 1; nxt.rd = 10; nxt.we = 1; nxt.br = 1; cycle();
    idle(); nxt.valid = 1; nxt.rs1 = 10; nxt.u1 = 1; cycle();
    idle(); cycle(); cycle(); cycle();

    // mem_stall held three cycles during a W match
    idle(); nxt.valid = 1; nxt.rd = 4; nxt.we = 1; cycle();
    idle(); cycle(); cycle();
    idle(); nxt.valid = 1; nxt.rs2 = 4; nxt.u2 = 1; nxt.ms = 1; nxt.wr = 32'h4444_0004;
    repeat (3) cycle();
    nxt.ms = 0; cycle();
    idle(); cycle(); cycle(); cycle();

    // reset arriving while a load-use stall is active
    idle(); nxt.valid = 1; nxt.rd = 12; nxt.we = 1; nxt.ld = 1; cycle();
    idle(); nxt.valid = 1; nxt.rs1 = 12; nxt.u1 = 1; cycle();
    nxt.rst = 1; cycle();
    nxt.rst = 0; cycle();
    cycle();

    // random traffic over a small register window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      idle();
      nxt.rst   = ($urandom_range(0, 99) == 0);
      nxt.valid = ($urandom_range(0, 9) != 0);
      nxt.rs1 = $urandom_range(0, 3); nxt.rs2 = $urandom_range(0, 3);
      nxt.u1 = $urandom_range(0, 1); nxt.u2 = $urandom_range(0, 1);
      nxt.rd = $urandom_range(0, 3);
      nxt.we = ($urandom_range(0, 3) != 0);
      nxt.ld = ($urandom_range(0, 2) == 0);
      nxt.br = ($urandom_range(0, 7) == 0);
      nxt.ms = ($urandom_range(0, 7) == 0);
      nxt.er = $urandom(); nxt.mr = $urandom(); nxt.wr = $urandom();
      cycle();
    end
    stim_done = 1;
  end

  initial begin
    int budget;
    budget = 0;
    wait (stim_done);
    while (sbq.size() != 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: stimulus did not complete, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
